cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among result producers: ALU, load/store unit and ROB commit path.
- Each producer port has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter selects one buffered result per cycle and drives it onto the registered CDB outputs (enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData) consumed by the ROB and reservation stations.
- A flush input discards all in-flight results on a branch mispredict.

---
 rtl/cdb_arbiter_pkg.sv | 24 ++
 rtl/cdb_arbiter_rr_picker.sv | 32 +++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared bus widths, free-slot constants and producer port indices for the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int DataBus = 32;
    localparam int TagBus  = 4;
    localparam int NameBus = 5;

    // A name of nameFree marks a result with no destination; it is never broadcast.
    localparam logic [TagBus-1:0]  tagFree  = 4'b0000;
    localparam logic [NameBus-1:0] nameFree = 5'b00000;
    localparam logic [DataBus-1:0] dataFree = 32'h0000_0000;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam int PORT_ALU = 0;
    localparam int PORT_LS  = 1;
    localparam int PORT_ROB = 2;

    function automatic logic is_free_name(input logic [NameBus-1:0] name);
        return (name == nameFree);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin select: first set request bit at or after i_ptr, wrapping modulo NREQ.
module cdb_arbiter_rr_picker #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    int   w_cand;
    logic w_hit;

    // Scan i_ptr, i_ptr+1, ... and latch the first hit; later hits are masked by o_any.
    always_comb begin
        o_grant = {NREQ{1'b0}};
        o_idx   = {PTR_W{1'b0}};
        o_any   = 1'b0;
        w_cand  = 0;
        w_hit   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand          = (int'(i_ptr) + k) % NREQ;
            w_hit           = ~o_any & i_req[w_cand];
            o_grant[w_cand] = o_grant[w_cand] | w_hit;
            o_idx           = w_hit ? PTR_W'(w_cand) : o_idx;
            o_any           = o_any | w_hit;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the common data bus among ALU, load/store and ROB producers through
// one-entry holding buffers and a round-robin pick onto registered CDB outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = DataBus,
    parameter int TAG_W  = TagBus,
    parameter int NAME_W = NameBus
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ*NAME_W-1:0]   req_name,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     enCDBWrt,
    output logic [NAME_W-1:0]        CDBwrtName,
    output logic [TAG_W-1:0]         CDBwrtTag,
    output logic [DATA_W-1:0]        CDBwrtData
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   r_buf_valid;
    logic [TAG_W-1:0]  r_buf_tag  [NREQ];
    logic [NAME_W-1:0] r_buf_name [NREQ];
    logic [DATA_W-1:0] r_buf_data [NREQ];
    logic [PTR_W-1:0]  r_rr_ptr;

    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_grant_idx;
    logic              w_grant_any;
    logic [NREQ-1:0]   w_load;
    logic [PTR_W-1:0]  w_ptr_next;

    // Grant depends only on buffer state, so req_ready never loops back through req_valid.
    cdb_arbiter_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req   (r_buf_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // Handshake: an empty buffer or one draining this cycle may take a new result.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        w_load    = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst & ~flush & (~r_buf_valid[i] | w_grant[i]);
            w_load[i]    = req_valid[i] & req_ready[i]
                           & ~is_free_name(NameBus'(req_name[i*NAME_W +: NAME_W]));
        end
    end

    // Pointer advance past the granted port; NREQ need not be a power of two.
    always_comb begin
        if (w_grant_idx == PTR_W'(NREQ - 1)) begin
            w_ptr_next = {PTR_W{1'b0}};
        end else begin
            w_ptr_next = w_grant_idx + PTR_W'(1);
        end
    end

    // Holding buffers: refill wins over drain so back-to-back results from one port never stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf_valid <= {NREQ{1'b0}};
        end else if (flush) begin
            r_buf_valid <= {NREQ{1'b0}};
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_load[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                    r_buf_name[i]  <= req_name[i*NAME_W +: NAME_W];
                    r_buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // CDB broadcast registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enCDBWrt   <= Disable;
            CDBwrtName <= NAME_W'(nameFree);
            CDBwrtTag  <= TAG_W'(tagFree);
            CDBwrtData <= DATA_W'(dataFree);
            r_rr_ptr   <= {PTR_W{1'b0}};
        end else if (flush || !w_grant_any) begin
            enCDBWrt   <= Disable;
            CDBwrtName <= NAME_W'(nameFree);
            CDBwrtTag  <= TAG_W'(tagFree);
            CDBwrtData <= DATA_W'(dataFree);
        end else begin
            enCDBWrt   <= Enable;
            CDBwrtName <= r_buf_name[w_grant_idx];
            CDBwrtTag  <= r_buf_tag[w_grant_idx];
            CDBwrtData <= r_buf_data[w_grant_idx];
            r_rr_ptr   <= w_ptr_next;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-level reference model compared every cycle,
// plus hand-computed expectations for reset, latency, contention, fairness, flush and free name.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int NW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*NW-1:0] req_name;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            enCDBWrt;
    logic [NW-1:0]   CDBwrtName;
    logic [TW-1:0]   CDBwrtTag;
    logic [DW-1:0]   CDBwrtData;

    cdb_arbiter #(.NREQ(N), .DATA_W(DW), .TAG_W(TW), .NAME_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_name   (req_name),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .enCDBWrt   (enCDBWrt),
        .CDBwrtName (CDBwrtName),
        .CDBwrtTag  (CDBwrtTag),
        .CDBwrtData (CDBwrtData)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Reference model: each port holds at most one pending result; the bus
    // serves the first occupied port at or after the pointer and shows it one edge later.
    bit            m_full [N];
    logic [TW-1:0] m_tag  [N];
    logic [NW-1:0] m_name [N];
    logic [DW-1:0] m_data [N];
    int            m_ptr = 0;
    bit            m_en  = 1'b0;
    logic [TW-1:0] m_otag  = tagFree;
    logic [NW-1:0] m_oname = nameFree;
    logic [DW-1:0] m_odata = dataFree;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit v, input logic [TW-1:0] tg,
                         input logic [NW-1:0] nm, input logic [DW-1:0] d);
        req_valid[p]          = v;
        req_tag[p*TW +: TW]   = tg;
        req_name[p*NW +: NW]  = nm;
        req_data[p*DW +: DW]  = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < N; p++) drive(p, 1'b0, 4'h0, 5'h00, 32'h0);
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit m_rdy(input int i);
        return (rst === 1'b1) && (flush === 1'b0) && (!m_full[i] || pick() == i);
    endfunction

    task automatic model_step();
        int g;
        bit r [N];
        g = pick();
        for (int i = 0; i < N; i++) r[i] = m_rdy(i);
        if (rst !== 1'b1 || flush === 1'b1) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            if (rst !== 1'b1) m_ptr = 0;
            m_en = 1'b0; m_otag = tagFree; m_oname = nameFree; m_odata = dataFree;
        end else begin
            if (g >= 0) begin
                m_en = 1'b1; m_otag = m_tag[g]; m_oname = m_name[g]; m_odata = m_data[g];
                m_full[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end else begin
                m_en = 1'b0; m_otag = tagFree; m_oname = nameFree; m_odata = dataFree;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && r[i] && req_name[i*NW +: NW] != nameFree) begin
                    m_full[i] = 1'b1;
                    m_tag[i]  = req_tag[i*TW +: TW];
                    m_name[i] = req_name[i*NW +: NW];
                    m_data[i] = req_data[i*DW +: DW];
                end
            end
        end
    endtask

    // Sample on the falling edge and compare everything against the model.
    task automatic look();
        logic [N-1:0] er;
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < N; i++) er[i] = m_rdy(i);
            chk("model_en",    32'(enCDBWrt),   32'(m_en));
            chk("model_name",  32'(CDBwrtName), 32'(m_oname));
            chk("model_tag",   32'(CDBwrtTag),  32'(m_otag));
            chk("model_data",  CDBwrtData,      m_odata);
            chk("model_ready", 32'(req_ready),  32'(er));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] fair_exp [5];
        int n0;
        bit acc0;
        fair_exp[0] = 32'hB0; fair_exp[1] = 32'hC2; fair_exp[2] = 32'hB1;
        fair_exp[3] = 32'hB2; fair_exp[4] = 32'hB3;

        // Reset held two edges with every port requesting.
        rst = 1'b0; flush = 1'b0;
        for (int p = 0; p < N; p++) drive(p, 1'b1, 4'h9, 5'h11, 32'hEEEE_0000 + 32'(p));
        adv();
        started = 1'b1;
        for (int c = 0; c < 2; c++) begin
            look();
            chk("rst_en",    32'(enCDBWrt),   32'd0);
            chk("rst_name",  32'(CDBwrtName), 32'(nameFree));
            chk("rst_ready", 32'(req_ready),  32'd0);
            adv();
        end
        rst = 1'b1; idle_all();
        look(); chk("rel_ready", 32'(req_ready), 32'b111); chk("rel_en", 32'(enCDBWrt), 32'd0); adv();
        look(); chk("rel_en2", 32'(enCDBWrt), 32'd0); adv();

        // Contention from pointer 0.
        for (int p = 0; p < N; p++) drive(p, 1'b1, 4'(p + 1), 5'(10 + p), 32'hA0 + 32'(p));
        look(); adv(); idle_all();
        look(); chk("cont_ready_c1", 32'(req_ready), 32'b001); adv();
        look(); chk("cont_d_c2", CDBwrtData, 32'hA0); chk("cont_ready_c2", 32'(req_ready), 32'b011); adv();
        look(); chk("cont_d_c3", CDBwrtData, 32'hA1); chk("cont_tag_c3", 32'(CDBwrtTag), 32'd2); adv();
        look(); chk("cont_d_c4", CDBwrtData, 32'hA2); chk("cont_en_c4", 32'(enCDBWrt), 32'd1); adv();
        look(); chk("cont_en_c5", 32'(enCDBWrt), 32'd0); adv();

        // Fairness: ALU streams, ROB issues once.
        n0 = 0;
        for (int c = 0; c < 9; c++) begin
            drive(PORT_ALU, c <= 6, 4'h5, 5'd20, 32'hB0 + 32'(n0));
            drive(PORT_ROB, c == 0, 4'h6, 5'd21, 32'hC2);
            look();
            if (c >= 2 && c <= 6) begin
                chk("fair_en",  32'(enCDBWrt), 32'd1);
                chk("fair_seq", CDBwrtData, fair_exp[c - 2]);
            end
            acc0 = req_valid[PORT_ALU] && m_rdy(PORT_ALU);
            adv();
            if (acc0) n0++;
        end
        idle_all();

        // Single uncontended request on LS: two-cycle latency, one-cycle pulse.
        drive(PORT_LS, 1'b1, 4'd3, 5'd7, 32'hDEADBEEF);
        look(); chk("single_en_c0", 32'(enCDBWrt), 32'd0); adv(); idle_all();
        look(); chk("single_en_c1", 32'(enCDBWrt), 32'd0); adv();
        look();
        chk("single_en_c2",   32'(enCDBWrt),   32'd1);
        chk("single_data_c2", CDBwrtData,      32'hDEADBEEF);
        chk("single_tag_c2",  32'(CDBwrtTag),  32'd3);
        chk("single_name_c2", 32'(CDBwrtName), 32'd7);
        adv();
        look(); chk("single_en_c3", 32'(enCDBWrt), 32'd0); adv();

        // Flush with all three buffers occupied.
        for (int p = 0; p < N; p++) drive(p, 1'b1, 4'(p + 4), 5'(1 + p), 32'hF0 + 32'(p));
        look(); adv(); idle_all(); flush = 1'b1;
        look(); chk("flush_ready", 32'(req_ready), 32'd0); chk("flush_en_c1", 32'(enCDBWrt), 32'd0); adv();
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            look(); chk("flush_en_after", 32'(enCDBWrt), 32'd0); adv();
        end

        // Free-name result: acknowledged, never broadcast.
        drive(PORT_ALU, 1'b1, 4'd2, nameFree, 32'h55);
        look(); chk("free_ready", 32'(req_ready[PORT_ALU]), 32'd1); adv(); idle_all();
        for (int c = 0; c < 3; c++) begin
            look(); chk("free_en", 32'(enCDBWrt), 32'd0); adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
